// File: rtl/apb_cfg_sequencer_if.sv
// APB master request port between apb_cfg_sequencer and the APB subsystem top.
interface apb_cfg_sequencer_if #(
  parameter int PDATA_WIDTH = 32,
  parameter int COEFF_WIDTH = 20,
  parameter int COMP        = 4,
  parameter int ADDR_WIDTH  = 8
);
  logic                   MTRANS;
  logic                   MWRITE;
  logic [COMP-1:0]        MSELx;
  logic [ADDR_WIDTH-1:0]  MADDR;
  logic [COEFF_WIDTH-1:0] MWDATA;
  logic [PDATA_WIDTH-1:0] MRDATA;

  modport master (output MTRANS, MWRITE, MSELx, MADDR, MWDATA, input MRDATA);
  modport slave  (input MTRANS, MWRITE, MSELx, MADDR, MWDATA, output MRDATA);
endinterface

// File: rtl/apb_cfg_sequencer.sv
// Walks a {wr, sel, addr, data} list in a synchronous ROM and issues each entry on the APB master port.
// Define CFG_SEQ_READBACK_EN to follow every write with a readback compare (err/err_cnt live).
module apb_cfg_sequencer #(
  parameter int PDATA_WIDTH = 32,
  parameter int COEFF_WIDTH = 20,
  parameter int COMP        = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int LIST_DEPTH  = 256,
  parameter int XFER_CYC    = 3,
  localparam int LA = $clog2(LIST_DEPTH),
  localparam int EW = 1 + COMP + ADDR_WIDTH + COEFF_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic [LA-1:0]          rom_addr,
  input  logic [EW-1:0]          rom_data,
  apb_cfg_sequencer_if.master    apb,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [7:0]             err_cnt,
  output logic [LA:0]            entry_cnt,
  output logic [PDATA_WIDTH-1:0] last_rdata
);
  localparam int CW = $clog2(XFER_CYC);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, ISSUE, WAIT, RB_ISSUE, RB_WAIT, RB_CHECK, DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]          cnt;
  logic                   wr_q;
  logic [COMP-1:0]        sel_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [COEFF_WIDTH-1:0] data_q;
  logic                   abort_seen;

  logic                   dec_wr;
  logic [COMP-1:0]        dec_sel;
  logic [ADDR_WIDTH-1:0]  dec_addr;
  logic [COEFF_WIDTH-1:0] dec_data;
  logic                   wait_done;
  logic                   last_entry;
  logic                   stop_after;
  logic                   entry_done;
  logic                   rb_wanted;

  assign dec_wr     = rom_data[EW-1];
  assign dec_sel    = rom_data[EW-2 -: COMP];
  assign dec_addr   = rom_data[COEFF_WIDTH +: ADDR_WIDTH];
  assign dec_data   = rom_data[COEFF_WIDTH-1:0];

  assign wait_done  = (cnt == '0);
  assign last_entry = (rom_addr == LA'(LIST_DEPTH - 1));
  // An abort arriving in the completing cycle itself still ends the run.
  assign stop_after = abort_seen | abort | last_entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = FETCH;
      FETCH:    state_nxt = DECODE;
      DECODE:   state_nxt = (dec_sel == '0) ? DONE : ISSUE;
      ISSUE:    state_nxt = WAIT;
      WAIT: begin
        if (wait_done) begin
          if (rb_wanted) state_nxt = RB_ISSUE;
          else           state_nxt = stop_after ? DONE : FETCH;
        end
      end
`ifdef CFG_SEQ_READBACK_EN
      RB_ISSUE: state_nxt = RB_WAIT;
      RB_WAIT:  if (wait_done) state_nxt = RB_CHECK;
      RB_CHECK: state_nxt = stop_after ? DONE : FETCH;
`endif
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    apb.MTRANS = 1'b0;
    apb.MWRITE = 1'b0;
    apb.MSELx  = '0;
    busy       = 1'b1;
    done       = 1'b0;
    entry_done = 1'b0;
    case (state)
      IDLE: busy = 1'b0;
      ISSUE: begin
        apb.MTRANS = 1'b1;
        apb.MWRITE = wr_q;
        apb.MSELx  = sel_q;
      end
      WAIT: begin
        apb.MWRITE = wr_q;
        apb.MSELx  = sel_q;
        entry_done = wait_done & ~rb_wanted;
      end
      RB_ISSUE: begin
        apb.MTRANS = 1'b1;
        apb.MSELx  = sel_q;
      end
      RB_WAIT:  apb.MSELx = sel_q;
      RB_CHECK: entry_done = 1'b1;
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign apb.MADDR  = addr_q;
  assign apb.MWDATA = data_q;

  // Transfer fields are latched once in DECODE and held through both the write and its readback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      wr_q       <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rom_addr   <= '0;
      entry_cnt  <= '0;
      last_rdata <= '0;
      abort_seen <= 1'b0;
    end else begin
      if (state == ISSUE || state == RB_ISSUE) cnt <= CW'(XFER_CYC - 1);
      else if (!wait_done)                     cnt <= cnt - CW'(1);

      if (state == IDLE && start) begin
        rom_addr   <= '0;
        entry_cnt  <= '0;
        abort_seen <= 1'b0;
      end else if (entry_done) begin
        entry_cnt  <= entry_cnt + (LA+1)'(1);
        abort_seen <= 1'b0;
        if (!stop_after) rom_addr <= rom_addr + LA'(1);
      end else if (abort && busy) begin
        abort_seen <= 1'b1;
      end

      if (state == DECODE && dec_sel != '0) begin
        wr_q   <= dec_wr;
        sel_q  <= dec_sel;
        addr_q <= dec_addr;
        data_q <= dec_data;
      end

      if (state == WAIT && wait_done && !wr_q) last_rdata <= apb.MRDATA;
    end
  end

`ifdef CFG_SEQ_READBACK_EN
  logic [COEFF_WIDTH-1:0] rb_q;
  logic                   err_q;
  logic [7:0]             err_cnt_q;

  // MRDATA is only guaranteed in the final wait cycle, so the readback is captured there and compared next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_q      <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (state == RB_WAIT && wait_done) rb_q <= apb.MRDATA[COEFF_WIDTH-1:0];
      if (state == IDLE && start) begin
        err_q     <= 1'b0;
        err_cnt_q <= '0;
      end else if (state == RB_CHECK && rb_q != data_q) begin
        err_q <= 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
  assign rb_wanted = wr_q;
`else
  assign err       = 1'b0;
  assign err_cnt   = '0;
  assign rb_wanted = 1'b0;
`endif

endmodule

// File: tb/tb_apb_cfg_sequencer.sv
// Self-checking bench for apb_cfg_sequencer: ROM + APB responder models, list-level reference model.
module tb_apb_cfg_sequencer;
  localparam int PW = 32, CWD = 20, COMP = 4, AW = 8, DEPTH = 256, XF = 3;
  localparam int LA = 8, EW = 1 + COMP + AW + CWD;
`ifdef CFG_SEQ_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [LA-1:0] rom_addr;
  logic [EW-1:0] rom_data;
  logic busy, done, err;
  logic [7:0] err_cnt;
  logic [LA:0] entry_cnt;
  logic [PW-1:0] last_rdata;

  apb_cfg_sequencer_if #(.PDATA_WIDTH(PW), .COEFF_WIDTH(CWD), .COMP(COMP), .ADDR_WIDTH(AW)) bus ();

  apb_cfg_sequencer #(
    .PDATA_WIDTH(PW), .COEFF_WIDTH(CWD), .COMP(COMP), .ADDR_WIDTH(AW),
    .LIST_DEPTH(DEPTH), .XFER_CYC(XF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rom_addr(rom_addr), .rom_data(rom_data), .apb(bus),
    .busy(busy), .done(done), .err(err), .err_cnt(err_cnt),
    .entry_cnt(entry_cnt), .last_rdata(last_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sel_index(input logic [COMP-1:0] s);
    for (int b = 0; b < COMP; b++) if (s[b]) return b;
    return 0;
  endfunction

  function automatic logic [63:0] pack(input logic w, input logic [COMP-1:0] s,
                                       input logic [AW-1:0] a, input logic [CWD-1:0] d);
    return {31'b0, w, s, a, d & {CWD{w}}};
  endfunction

  function automatic logic [PW-1:0] base_val(input logic [31:0] seed, input int i, input int j);
    return seed ^ (32'(i) * 32'h9E3779B1) ^ (32'(j) * 32'h85EBCA6B);
  endfunction

  // ROM with one-cycle read latency
  logic [EW-1:0] rom [DEPTH];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // APB responder: register file per slave; a chosen write value can be corrupted on store
  logic [PW-1:0]  mem [COMP][256];
  logic           mem_reload = 1'b0, poke_req = 1'b0, corrupt_on = 1'b0;
  logic [31:0]    mem_seed = '0;
  int             poke_idx = 0;
  logic [AW-1:0]  poke_addr = '0;
  logic [PW-1:0]  poke_val = '0;
  logic [CWD-1:0] corrupt_match = '0;
  logic [PW-1:0]  mrdata_q = '0;
  assign bus.MRDATA = mrdata_q;

  function automatic logic [CWD-1:0] stored_val(input logic [CWD-1:0] d);
    return (corrupt_on && d == corrupt_match) ? d + CWD'(1) : d;
  endfunction

  always @(posedge clk) begin
    if (mem_reload) begin
      for (int i = 0; i < COMP; i++)
        for (int j = 0; j < 256; j++) mem[i][j] = base_val(mem_seed, i, j);
    end else if (poke_req) begin
      mem[poke_idx][poke_addr] = poke_val;
    end else if (bus.MTRANS) begin
      if (bus.MWRITE) mem[sel_index(bus.MSELx)][bus.MADDR] = {{(PW-CWD){1'b0}}, stored_val(bus.MWDATA)};
      else            mrdata_q <= mem[sel_index(bus.MSELx)][bus.MADDR];
    end
  end

  // Transaction / done monitor, sampled mid-cycle
  logic [63:0] mon_trans [8192];
  int mon_cyc [8192];
  int tn = 0, dn = 0, done_cyc = 0;
  always @(negedge clk) begin
    if (bus.MTRANS && tn < 8192) begin
      mon_trans[tn] <= pack(bus.MWRITE, bus.MSELx, bus.MADDR, bus.MWDATA);
      mon_cyc[tn]   <= cyc;
      tn            <= tn + 1;
    end
    if (done) begin
      dn       <= dn + 1;
      done_cyc <= cyc;
    end
  end

  // Reference model state
  logic [PW-1:0] mmem [COMP][256];
  logic [PW-1:0] exp_last = '0;
  logic [63:0]   exp_trans [$];
  int            exp_tcyc [$];
  int            exp_n, exp_done_rel, exp_errs, exp_rom_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_entry(input int i, input logic w, input logic [COMP-1:0] s,
                           input logic [AW-1:0] a, input logic [CWD-1:0] d);
    rom[i] = {w, s, a, d};
  endtask

  task automatic clear_rom();
    for (int i = 0; i < DEPTH; i++) rom[i] = '0;
  endtask

  task automatic reload_mem(input logic [31:0] seed);
    mem_seed = seed;
    mem_reload = 1'b1;
    @(posedge clk); #1;
    mem_reload = 1'b0;
    for (int i = 0; i < COMP; i++)
      for (int j = 0; j < 256; j++) mmem[i][j] = base_val(seed, i, j);
  endtask

  task automatic poke_mem(input int idx, input logic [AW-1:0] a, input logic [PW-1:0] v);
    poke_idx = idx; poke_addr = a; poke_val = v; poke_req = 1'b1;
    @(posedge clk); #1;
    poke_req = 1'b0;
    mmem[idx][a] = v;
  endtask

  // List-level model: relative cycle of each MTRANS, done cycle, counts, captured data
  task automatic model_run(input int abort_rel);
    logic [EW-1:0] e;
    logic w;
    logic [COMP-1:0] s;
    logic [AW-1:0] a;
    logic [CWD-1:0] d, stv;
    int t, len, idx;
    bit stop;
    t = 1; stop = 0;
    exp_trans.delete(); exp_tcyc.delete();
    exp_n = 0; exp_errs = 0; exp_done_rel = -1; exp_rom_addr = 0;
    for (int i = 0; i < DEPTH && !stop; i++) begin
      e = rom[i];
      w = e[EW-1]; s = e[EW-2 -: COMP]; a = e[CWD +: AW]; d = e[CWD-1:0];
      exp_rom_addr = i;
      if (s == '0) begin
        exp_done_rel = t + 2;
        stop = 1;
      end else begin
        len = 3 + XF;
        idx = sel_index(s);
        exp_trans.push_back(pack(w, s, a, d)); exp_tcyc.push_back(t + 2);
        if (w) begin
          stv = stored_val(d);
          mmem[idx][a] = {{(PW-CWD){1'b0}}, stv};
          if (RB) begin
            exp_trans.push_back(pack(1'b0, s, a, d)); exp_tcyc.push_back(t + 3 + XF);
            len += XF + 2;
            if (stv != d) exp_errs++;
          end
        end else begin
          exp_last = mmem[idx][a];
        end
        exp_n++;
        if ((abort_rel >= t && abort_rel <= t + len - 1) || i == DEPTH - 1) begin
          exp_done_rel = t + len;
          stop = 1;
        end
        t += len;
      end
    end
    if (exp_errs > 255) exp_errs = 255;
  endtask

  task automatic run_list(input string tag, input int abort_rel, input int restart_rel);
    int bt, bd, c0, k, ntr;
    bt = tn; bd = dn;
    model_run(abort_rel);
    @(posedge clk); #1;
    c0 = cyc; start = 1'b1; abort = 1'b0;
    k = 0;
    while (dn == bd && k < 20000) begin
      @(posedge clk); #1;
      k++;
      start = (k == restart_rel);
      abort = (k == abort_rel);
    end
    start = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk); #1;
    check({tag, "/done_seen"}, 64'(dn != bd), 64'd1);
    check({tag, "/done_cyc"}, 64'(done_cyc - c0), 64'(exp_done_rel));
    check({tag, "/done_pulses"}, 64'(dn - bd), 64'd1);
    check({tag, "/busy_after"}, 64'(busy), 64'd0);
    check({tag, "/entry_cnt"}, 64'(entry_cnt), 64'(exp_n));
    check({tag, "/rom_addr"}, 64'(rom_addr), 64'(exp_rom_addr));
    check({tag, "/err"}, 64'(err), 64'(exp_errs != 0));
    check({tag, "/err_cnt"}, 64'(err_cnt), 64'(exp_errs));
    check({tag, "/last_rdata"}, 64'(last_rdata), 64'(exp_last));
    ntr = tn - bt;
    check({tag, "/trans_count"}, 64'(ntr), 64'(exp_trans.size()));
    for (int i = 0; i < ntr && i < exp_trans.size(); i++) begin
      check({tag, "/trans"}, mon_trans[bt + i], exp_trans[i]);
      check({tag, "/trans_cyc"}, 64'(mon_cyc[bt + i] - c0), 64'(exp_tcyc[i]));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "/MTRANS"}, 64'(bus.MTRANS), 64'd0);
    check({tag, "/MSELx"}, 64'(bus.MSELx), 64'd0);
    check({tag, "/MWRITE"}, 64'(bus.MWRITE), 64'd0);
    check({tag, "/MADDR"}, 64'(bus.MADDR), 64'd0);
    check({tag, "/MWDATA"}, 64'(bus.MWDATA), 64'd0);
    check({tag, "/busy"}, 64'(busy), 64'd0);
    check({tag, "/done"}, 64'(done), 64'd0);
    check({tag, "/err"}, 64'(err), 64'd0);
    check({tag, "/err_cnt"}, 64'(err_cnt), 64'd0);
    check({tag, "/entry_cnt"}, 64'(entry_cnt), 64'd0);
    check({tag, "/rom_addr"}, 64'(rom_addr), 64'd0);
    check({tag, "/last_rdata"}, 64'(last_rdata), 64'd0);
  endtask

  initial begin
    int n, ab;
    $display("[TB] apb_cfg_sequencer bench, readback=%0d", RB);
    clear_rom();
    repeat (3) @(posedge clk); #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    reload_mem(32'h1234_5678);

    clear_rom();
    set_entry(0, 1'b1, 4'b0001, 8'd0, 20'h00123);
    set_entry(1, 1'b1, 4'b0100, 8'd3, 20'h00001);
    run_list("basic", -1, -1);

    clear_rom();
    run_list("empty", -1, -1);

    clear_rom();
    set_entry(0, 1'b1, 4'b0001, 8'd0, 20'h00123);
    set_entry(1, 1'b1, 4'b0100, 8'd3, 20'h00001);
    corrupt_on = 1'b1; corrupt_match = 20'h00123;
    run_list("rb_err", -1, -1);
    corrupt_on = 1'b0;

    clear_rom();
    set_entry(0, 1'b0, 4'b0010, 8'd5, 20'h0);
    poke_mem(1, 8'd5, 32'hDEADBEEF);
    run_list("read", -1, -1);

    clear_rom();
    for (int i = 0; i < 5; i++) set_entry(i, 1'b1, COMP'(1 << (i % COMP)), AW'(i), CWD'(100 + i));
    run_list("abort", RB ? 16 : 11, 4);

    for (int i = 0; i < DEPTH; i++)
      set_entry(i, 1'($urandom_range(0, 1)), COMP'(1 << $urandom_range(0, COMP - 1)),
                AW'($urandom), CWD'($urandom));
    run_list("full", -1, -1);

    for (int r = 0; r < 6; r++) begin
      clear_rom();
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++)
        set_entry(i, 1'($urandom_range(0, 1)), COMP'(1 << $urandom_range(0, COMP - 1)),
                  AW'($urandom_range(0, 7)), CWD'($urandom));
      corrupt_on = 1'($urandom_range(0, 1));
      corrupt_match = rom[0][CWD-1:0];
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : -1;
      run_list("rand", ab, -1);
      corrupt_on = 1'b0;
    end

    clear_rom();
    set_entry(0, 1'b1, 4'b1000, 8'h22, 20'h00005);
    set_entry(1, 1'b1, 4'b0001, 8'h23, 20'h00006);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("pre_reset/busy", 64'(busy), 64'd1);
    check("pre_reset/MSELx", 64'(bus.MSELx), 64'b1000);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_last = '0;
    reload_mem(32'hCAFE_0001);
    run_list("after_reset", -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
